pulse_seq_checker: RTL and testbench
====================================

PULSE_SEQ_CHECKER -- requirements
Module: pulse_seq_checker

Interface
REQ-001 Parameter LOCK_ROUNDS, default 2, number of consecutive error-free six-phase rounds required before lock is asserted (legal range 1..15).
REQ-002 clk  input  1  single system clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 pulse_in  input  6  one-hot phase word from the sequential pulse generator; expected order 100000, 010000, 001000, 000100, 000010, 000001, then repeat.
REQ-005 clr  input  1  synchronous clear of err, err_cnt and round_cnt.
REQ-006 lock  output  1  high while the FSM is in LOCKED.
REQ-007 err  output  1  sticky flag, set on any sequence error in LOCKED.
REQ-008 err_cnt  output  8  count of sequence errors, saturating at 255.
REQ-009 round_cnt  output  16  count of complete rounds while LOCKED, saturating at 65535.
REQ-010 phase  output  3  index 0..5 of the last matched phase; 0 in HUNT.
REQ-011 onehot_err  output  1  registered non-one-hot detect pulse (see Configuration).

Function
REQ-012 pulse_in shall be sampled on every posedge clk; all outputs shall be registered and updated on the same edge (one-cycle latency from input to output).
REQ-013 FSM states shall be HUNT, ACQ and LOCKED; an internal expected-phase pointer shall hold the index 0..5 of the next required word.
REQ-014 HUNT: on pulse_in == 100000, go to ACQ with pointer = 1, phase = 0; on any other value, stay in HUNT.
REQ-015 ACQ: a match shall advance the pointer mod 6; a match of 000001 shall increment the round counter; on reaching LOCK_ROUNDS rounds, go to LOCKED with lock = 1 on that same edge.
REQ-016 ACQ mismatch: return to HUNT silently, with no change to err or err_cnt.
REQ-017 LOCKED: a match shall advance the pointer; a match of 000001 shall increment round_cnt, holding at 65535.
REQ-018 LOCKED mismatch: set err, increment err_cnt (holding at 255), clear lock, and go to HUNT.
REQ-019 Resync on mismatch: if the mismatching word is 100000 (in ACQ or LOCKED), go directly to ACQ with pointer = 1 instead of HUNT; the error is still counted if it occurred in LOCKED.
REQ-020 All-zero and multi-hot words shall be treated as mismatches.
REQ-021 Wrap-around: after a match of 000001, the pointer shall wrap to 0 (expect 100000).
REQ-022 clr shall take priority over a same-cycle counter or err update: counters and err go to 0, and that cycle's event is not counted.
REQ-023 clr shall not affect the FSM state, the pointer or lock.

Reset
REQ-024 While rst_n is low: FSM = HUNT, pointer = 0, round counter = 0, lock = 0, err = 0, err_cnt = 0, round_cnt = 0, phase = 0, onehot_err = 0.
REQ-025 Asserting rst_n mid-round shall discard all progress immediately, independent of clk.

Configuration
REQ-026 Macro PULSE_SEQ_CHECKER_ONEHOT_CHK_EN defined: onehot_err shall be 1 for exactly one cycle after each sample where popcount(pulse_in) != 1, in any state.
REQ-027 Macro undefined: onehot_err shall be tied to 0, the detect logic shall be absent, and all other behaviour shall be identical.

Verification
REQ-028 Reset release, then a correct generator sequence from 100000 (LOCK_ROUNDS = 2) -> lock = 1 after the 12th sampling edge; round_cnt = 1 after the 18th edge; err = 0.
REQ-029 Locked, then 001000 injected where 010000 is expected -> err = 1, err_cnt = 1, lock = 0, FSM in HUNT; relock after 12 further correct phases starting at 100000.
REQ-030 Locked, then 100000 injected mid-round -> err_cnt increments, FSM in ACQ with phase = 0, no HUNT cycle.
REQ-031 Force 255 errors, then one more -> err_cnt holds at 255; pulse clr in the same cycle as an error -> err = 0, err_cnt = 0.
REQ-032 With the macro defined, pulse_in = 000000 then 110000 -> onehot_err high for 2 cycles; with the macro undefined -> onehot_err stays 0.
REQ-033 Assert rst_n low between clock edges while locked -> all outputs 0 immediately, with no clk edge required.

Source files
------------

// File: rtl/pulse_seq_checker.sv
// Checker for a six-phase one-hot pulse generator: hunts for 100000, acquires LOCK_ROUNDS clean rounds, then counts rounds and errors while locked.
// Optional build macro PULSE_SEQ_CHECKER_ONEHOT_CHK_EN adds a registered non-one-hot detect on onehot_err.
module pulse_seq_checker #(
  parameter int LOCK_ROUNDS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  pulse_in,
  input  logic        clr,
  output logic        lock,
  output logic        err,
  output logic [7:0]  err_cnt,
  output logic [15:0] round_cnt,
  output logic [2:0]  phase,
  output logic        onehot_err
);

  typedef enum logic [1:0] {HUNT, ACQ, LOCKED} state_t;

  localparam logic [3:0] LOCK_R = 4'(LOCK_ROUNDS);
  localparam logic [5:0] FIRST_WORD = 6'b100000;

  state_t      state, state_nxt;
  logic [2:0]  ptr, ptr_nxt, ptr_adv, phase_nxt;
  logic [3:0]  acq_cnt, acq_cnt_nxt;
  logic        err_nxt;
  logic [7:0]  err_cnt_nxt;
  logic [15:0] round_cnt_nxt;
  logic [5:0]  expect_word;
  logic        match, is_first;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign expect_word = FIRST_WORD >> ptr;
  assign match       = (pulse_in == expect_word);
  assign is_first    = (pulse_in == FIRST_WORD);
  assign ptr_adv     = (ptr == 3'd5) ? 3'd0 : ptr + 3'd1;
  assign lock        = (state == LOCKED);

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    phase_nxt     = phase;
    acq_cnt_nxt   = acq_cnt;
    err_nxt       = err;
    err_cnt_nxt   = err_cnt;
    round_cnt_nxt = round_cnt;

    case (state)
      HUNT: begin
        phase_nxt   = 3'd0;
        ptr_nxt     = 3'd0;
        acq_cnt_nxt = 4'd0;
        if (is_first) begin
          state_nxt = ACQ;
          ptr_nxt   = 3'd1;
        end
      end
      ACQ, LOCKED: begin
        if (match) begin
          ptr_nxt   = ptr_adv;
          phase_nxt = ptr;
          if (ptr == 3'd5) begin
            if (state == LOCKED) begin
              round_cnt_nxt = sat_inc16(round_cnt);
            end else if (acq_cnt + 4'd1 == LOCK_R) begin
              state_nxt   = LOCKED;
              acq_cnt_nxt = 4'd0;
            end else begin
              acq_cnt_nxt = acq_cnt + 4'd1;
            end
          end
        end else begin
          // A mismatching 100000 is treated as a fresh start rather than a drop to HUNT.
          if (state == LOCKED) begin
            err_nxt     = 1'b1;
            err_cnt_nxt = sat_inc8(err_cnt);
          end
          acq_cnt_nxt = 4'd0;
          phase_nxt   = 3'd0;
          state_nxt   = is_first ? ACQ : HUNT;
          ptr_nxt     = is_first ? 3'd1 : 3'd0;
        end
      end
      default: begin
        state_nxt   = HUNT;
        ptr_nxt     = 3'd0;
        phase_nxt   = 3'd0;
        acq_cnt_nxt = 4'd0;
      end
    endcase

    if (clr) begin
      err_nxt       = 1'b0;
      err_cnt_nxt   = 8'd0;
      round_cnt_nxt = 16'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      ptr       <= 3'd0;
      acq_cnt   <= 4'd0;
      phase     <= 3'd0;
      err       <= 1'b0;
      err_cnt   <= 8'd0;
      round_cnt <= 16'd0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      acq_cnt   <= acq_cnt_nxt;
      phase     <= phase_nxt;
      err       <= err_nxt;
      err_cnt   <= err_cnt_nxt;
      round_cnt <= round_cnt_nxt;
    end
  end

`ifdef PULSE_SEQ_CHECKER_ONEHOT_CHK_EN
  logic not_onehot;
  assign not_onehot = (pulse_in == 6'd0) || ((pulse_in & (pulse_in - 6'd1)) != 6'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) onehot_err <= 1'b0;
    else        onehot_err <= not_onehot;
  end
`else
  assign onehot_err = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_seq_checker.sv
// Scoreboard bench for pulse_seq_checker: a run-length reference model predicts each cycle's outputs.
module tb_pulse_seq_checker;
  localparam int LR = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  pulse_in = 6'd0;
  logic        clr = 1'b0;
  logic        lock, err, onehot_err;
  logic [7:0]  err_cnt;
  logic [15:0] round_cnt;
  logic [2:0]  phase;

  pulse_seq_checker #(.LOCK_ROUNDS(LR)) dut (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .clr(clr),
    .lock(lock), .err(err), .err_cnt(err_cnt), .round_cnt(round_cnt),
    .phase(phase), .onehot_err(onehot_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        lock;
    logic        err;
    logic [7:0]  ecnt;
    logic [15:0] rnd;
    logic [2:0]  ph;
    logic        oh;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int total = 0;
  int bad = 0;

  // Model: run = words matched in the current aligned run (0 = hunting).
  int run = 0;
  bit m_err = 0;
  int m_ecnt = 0;
  int m_rnd = 0;

  task automatic check(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic logic [5:0] next_word();
    logic [5:0] w;
    w = 6'b100000;
    return w >> (run % 6);
  endfunction

  task automatic model(input logic [5:0] w, input logic c);
    bit   was_locked;
    exp_t e;
    was_locked = (run >= 6 * LR);
    if (run == 0) begin
      run = (w == 6'b100000) ? 1 : 0;
    end else if (w == next_word()) begin
      run++;
      if (was_locked && (run % 6 == 0) && m_rnd < 65535) m_rnd++;
    end else begin
      if (was_locked) begin
        m_err = 1;
        if (m_ecnt < 255) m_ecnt++;
      end
      run = (w == 6'b100000) ? 1 : 0;
    end
    if (c) begin
      m_err = 0; m_ecnt = 0; m_rnd = 0;
    end
    if (run > 6 * LR + 6) run -= 6;
    e.lock = (run >= 6 * LR);
    e.err  = m_err;
    e.ecnt = 8'(m_ecnt);
    e.rnd  = 16'(m_rnd);
    e.ph   = (run == 0) ? 3'd0 : 3'((run - 1) % 6);
`ifdef PULSE_SEQ_CHECKER_ONEHOT_CHK_EN
    e.oh   = ($countones(w) != 1);
`else
    e.oh   = 1'b0;
`endif
    q.push_back(e);
  endtask

  task automatic step(input logic [5:0] w, input logic c);
    @(negedge clk);
    pulse_in = w;
    clr = c;
    model(w, c);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic bad_word(output logic [5:0] w);
    int r;
    r = $urandom_range(0, 3);
    case (r)
      0: w = 6'b000000;
      1: w = 6'b110000;
      2: w = 6'b100000;
      default: w = 6'(1 << $urandom_range(0, 5));
    endcase
    if (w == next_word()) w = 6'b000000;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_lock"}, int'(lock), 0);
    check({tag, "_err"}, int'(err), 0);
    check({tag, "_err_cnt"}, int'(err_cnt), 0);
    check({tag, "_round_cnt"}, int'(round_cnt), 0);
    check({tag, "_phase"}, int'(phase), 0);
    check({tag, "_onehot_err"}, int'(onehot_err), 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      check("sb_lock", int'(lock), int'(mon_e.lock));
      check("sb_err", int'(err), int'(mon_e.err));
      check("sb_err_cnt", int'(err_cnt), int'(mon_e.ecnt));
      check("sb_round_cnt", int'(round_cnt), int'(mon_e.rnd));
      check("sb_phase", int'(phase), int'(mon_e.ph));
      check("sb_onehot_err", int'(onehot_err), int'(mon_e.oh));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] w;
    int r;
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Initial acquisition and first locked round.
    for (int i = 0; i < 18; i++) begin
      step(next_word(), 1'b0);
      settle();
      if (i == 10) check("acq_lock_11", int'(lock), 0);
      if (i == 11) check("acq_lock_12", int'(lock), 1);
      if (i == 16) check("round_17", int'(round_cnt), 0);
      if (i == 17) begin
        check("round_18", int'(round_cnt), 1);
        check("err_18", int'(err), 0);
      end
    end

    // Wrong phase while locked, then relock.
    step(6'b100000, 1'b0);
    step(6'b001000, 1'b0);
    settle();
    check("inj_err", int'(err), 1);
    check("inj_err_cnt", int'(err_cnt), 1);
    check("inj_lock", int'(lock), 0);
    check("inj_phase", int'(phase), 0);
    for (int i = 0; i < 12; i++) step(next_word(), 1'b0);
    settle();
    check("relock", int'(lock), 1);

    // Resync on 100000 mid-round.
    step(6'b100000, 1'b0);
    step(6'b010000, 1'b0);
    step(6'b100000, 1'b0);
    settle();
    check("resync_err_cnt", int'(err_cnt), 2);
    check("resync_phase", int'(phase), 0);
    step(6'b010000, 1'b0);
    settle();
    check("resync_acq_phase", int'(phase), 1);

    // Saturate err_cnt.
    for (int k = 0; k < 256; k++) begin
      for (int i = 0; i < 12; i++) step(next_word(), 1'b0);
      bad_word(w);
      step(w, 1'b0);
    end
    settle();
    check("sat_err_cnt", int'(err_cnt), 255);

    // clr in the same cycle as an error.
    for (int i = 0; i < 12; i++) step(next_word(), 1'b0);
    step(6'b000000, 1'b1);
    settle();
    check("clr_err", int'(err), 0);
    check("clr_err_cnt", int'(err_cnt), 0);
    check("clr_lock", int'(lock), 0);

    // Non-one-hot words back to back.
    step(6'b000000, 1'b0);
    settle();
`ifdef PULSE_SEQ_CHECKER_ONEHOT_CHK_EN
    check("oh_zero", int'(onehot_err), 1);
`else
    check("oh_zero", int'(onehot_err), 0);
`endif
    step(6'b110000, 1'b0);
    step(6'b100000, 1'b0);
    settle();
    check("oh_clean", int'(onehot_err), 0);

    // Randomised traffic.
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 80)      w = next_word();
      else if (r < 85) w = 6'b100000;
      else if (r < 90) w = 6'b000000;
      else             w = 6'($urandom_range(0, 63));
      step(w, ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
    end

    // Asynchronous reset while locked.
    for (int i = 0; i < 14; i++) step(next_word(), 1'b0);
    settle();
    check("pre_rst_lock", int'(lock), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    run = 0; m_err = 0; m_ecnt = 0; m_rnd = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step(next_word(), 1'b0);

    repeat (3) @(posedge clk);
    #3;
    check("sb_drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
